// File: rtl/game_pkg.sv
// Shared game types: the state seen by the renderer and the sound ids seen by the audio block.
package game_pkg;

    typedef enum logic [2:0] {
        MENU,
        PLAYING,
        PAUSED,
        DYING,
        GAME_OVER,
        WIN
    } state_t;

    typedef enum logic [2:0] {
        UI_PRESS,
        NEXTLEVEL,
        CRASH,
        CELEBRATION,
        GAMEOVER,
        PAUSE
    } sound_t;

    localparam int SND_W = 3;

endpackage

// File: rtl/game_fsm_if.sv
// Sound-request handshake between the game sequencer and the audio block.
interface game_fsm_if;
    import game_pkg::*;

    logic   snd_valid;
    sound_t snd_id;
    logic   snd_ready;

    modport master (output snd_valid, output snd_id, input snd_ready);
    modport slave  (input snd_valid, input snd_id, output snd_ready);
endinterface

// File: rtl/sound_fifo.sv
// Small sound-request FIFO. A push into a full FIFO is dropped and flagged,
// unless a pop frees the slot in the same cycle.
module sound_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push & full & ~do_pop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/game_fsm.sv
// Game sequencer: button edge detection, game state, level/lives bookkeeping,
// timed death phase and sound-request generation into a small FIFO.
module game_fsm
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = 16,
    parameter int LIVES       = 3,
    parameter int DEAD_CYCLES = 50_000_000,
    parameter int SND_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            pause,
    input  logic                            collision,
    input  logic                            reached_end,
    output state_t                          state,
    output logic [$clog2(NUM_LEVELS)-1:0]   level,
    output logic [$clog2(LIVES+1)-1:0]      lives,
    output logic                            respawn,
    game_fsm_if.master                      snd,
    output logic                            snd_overflow
);
    localparam int LVL_W = $clog2(NUM_LEVELS);
    localparam int LIV_W = $clog2(LIVES + 1);
    localparam int TMR_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LIV_W-1:0] LIVES_INIT = LIV_W'(LIVES);
    localparam logic [TMR_W-1:0] TMR_INIT   = TMR_W'(DEAD_CYCLES - 1);

    logic             start_q, pause_q, end_q;
    logic             start_edge, pause_edge, end_edge;
    state_t           state_n;
    logic [LVL_W-1:0] level_n;
    logic [LIV_W-1:0] lives_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             respawn_n;
    logic             push;
    sound_t           push_id;
    logic [SND_W-1:0] fifo_dout;
    logic             fifo_empty;

    assign start_edge = start & ~start_q;
    assign pause_edge = pause & ~pause_q;
    assign end_edge   = reached_end & ~end_q;

    // State, counters, respawn strobe and button history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MENU;
            level   <= '0;
            lives   <= LIVES_INIT;
            timer   <= '0;
            respawn <= 1'b0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state   <= state_n;
            level   <= level_n;
            lives   <= lives_n;
            timer   <= timer_n;
            respawn <= respawn_n;
            start_q <= start;
            pause_q <= pause;
            end_q   <= reached_end;
        end
    end

    // Next-state logic; the if/else order sets event priority and at most one sound per cycle.
    always_comb begin
        state_n   = state;
        level_n   = level;
        lives_n   = lives;
        timer_n   = timer;
        respawn_n = 1'b0;
        push      = 1'b0;
        push_id   = UI_PRESS;
        case (state)
            MENU: begin
                if (start_edge) begin
                    state_n   = PLAYING;
                    level_n   = '0;
                    lives_n   = LIVES_INIT;
                    respawn_n = 1'b1;
                    push      = 1'b1;
                    push_id   = UI_PRESS;
                end
            end
            PLAYING: begin
                if (collision) begin
                    push = 1'b1;
                    if (lives > LIV_W'(1)) begin
                        state_n = DYING;
                        lives_n = lives - LIV_W'(1);
                        timer_n = TMR_INIT;
                        push_id = CRASH;
                    end else begin
                        state_n = GAME_OVER;
                        lives_n = '0;
                        push_id = GAMEOVER;
                    end
                end else if (end_edge) begin
                    push = 1'b1;
                    if (level == LAST_LEVEL) begin
                        state_n = WIN;
                        push_id = CELEBRATION;
                    end else begin
                        level_n   = level + LVL_W'(1);
                        respawn_n = 1'b1;
                        push_id   = NEXTLEVEL;
                    end
                end else if (pause_edge) begin
                    state_n = PAUSED;
                    push    = 1'b1;
                    push_id = PAUSE;
                end
            end
            PAUSED: begin
                if (pause_edge) begin
                    state_n = PLAYING;
                    push    = 1'b1;
                    push_id = PAUSE;
                end
            end
            DYING: begin
                if (timer == '0) begin
                    state_n   = PLAYING;
                    respawn_n = 1'b1;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            GAME_OVER, WIN: begin
                if (start_edge) begin
                    state_n = MENU;
                    push    = 1'b1;
                    push_id = UI_PRESS;
                end
            end
            default: state_n = MENU;
        endcase
    end

    sound_fifo #(
        .DEPTH (SND_DEPTH),
        .W     (SND_W)
    ) u_sound_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (push_id),
        .pop      (snd.snd_ready),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .overflow (snd_overflow)
    );

    assign snd.snd_valid = ~fifo_empty;
    assign snd.snd_id    = sound_t'(fifo_dout);

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: directed scenarios plus a randomized run against a queue-based reference model.
module tb_game_fsm;
    import game_pkg::*;

    localparam int NL = 4;
    localparam int LV = 2;
    localparam int DC = 5;
    localparam int SD = 4;
    localparam int LVL_W = $clog2(NL);
    localparam int LIV_W = $clog2(LV + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             start, pause, collision, reached_end;
    state_t           state;
    logic [LVL_W-1:0] level;
    logic [LIV_W-1:0] lives;
    logic             respawn;
    logic             snd_overflow;

    game_fsm_if snd_if ();

    game_fsm #(
        .NUM_LEVELS  (NL),
        .LIVES       (LV),
        .DEAD_CYCLES (DC),
        .SND_DEPTH   (SD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .collision    (collision),
        .reached_end  (reached_end),
        .state        (state),
        .level        (level),
        .lives        (lives),
        .respawn      (respawn),
        .snd          (snd_if.master),
        .snd_overflow (snd_overflow)
    );

    always #5 clk = ~clk;

    int     pass_cnt = 0;
    int     chk_cnt  = 0;
    sound_t obs[$];

    // Reference model: game rules as plain integers, the sound FIFO as a bounded queue.
    state_t m_state;
    int     m_level, m_lives, m_left;
    bit     m_respawn, m_ovf;
    sound_t m_q[$];
    bit     p_start, p_pause, p_end;

    task automatic model_step();
        bit     se, pe, ee, pop, has_snd, full;
        sound_t s;
        se = start && !p_start;
        pe = pause && !p_pause;
        ee = reached_end && !p_end;
        pop = (m_q.size() > 0) && snd_if.snd_ready;
        has_snd = 0;
        s = UI_PRESS;
        m_respawn = 0;
        case (m_state)
            MENU: if (se) begin
                m_state = PLAYING; m_level = 0; m_lives = LV; m_respawn = 1; has_snd = 1; s = UI_PRESS;
            end
            PLAYING: begin
                if (collision) begin
                    has_snd = 1;
                    if (m_lives > 1) begin m_state = DYING; m_lives--; m_left = DC; s = CRASH; end
                    else begin m_state = GAME_OVER; m_lives = 0; s = GAMEOVER; end
                end else if (ee) begin
                    has_snd = 1;
                    if (m_level == NL - 1) begin m_state = WIN; s = CELEBRATION; end
                    else begin m_level++; m_respawn = 1; s = NEXTLEVEL; end
                end else if (pe) begin
                    m_state = PAUSED; has_snd = 1; s = PAUSE;
                end
            end
            PAUSED: if (pe) begin m_state = PLAYING; has_snd = 1; s = PAUSE; end
            DYING: begin
                m_left--;
                if (m_left == 0) begin m_state = PLAYING; m_respawn = 1; end
            end
            default: if (se) begin m_state = MENU; has_snd = 1; s = UI_PRESS; end
        endcase
        full = (m_q.size() == SD);
        if (pop) void'(m_q.pop_front());
        if (has_snd) begin
            if (!full || pop) m_q.push_back(s);
            else m_ovf = 1;
        end
        p_start = start;
        p_pause = pause;
        p_end   = reached_end;
    endtask

    // Model tracks the DUT edge by edge, with the same asynchronous reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = MENU; m_level = 0; m_lives = LV; m_left = 0;
            m_respawn = 0; m_ovf = 0; m_q.delete();
            p_start = 0; p_pause = 0; p_end = 0;
        end else begin
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start = 0; pause = 0; collision = 0; reached_end = 0;
    endtask

    task automatic do_reset();
        idle();
        snd_if.snd_ready = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic tick_obs();
        if (snd_if.snd_valid && snd_if.snd_ready) obs.push_back(snd_if.snd_id);
        tick();
    endtask

    task automatic drain();
        obs.delete();
        snd_if.snd_ready = 1;
        for (int i = 0; i < 12; i++) tick_obs();
        snd_if.snd_ready = 0;
    endtask

    task automatic test_reset();
        idle();
        snd_if.snd_ready = 0;
        reset = 1;
        #2;
        chk_cnt++; if (state !== MENU) $display("FAIL reset_state: got %0d want %0d", state, MENU); else pass_cnt++;
        chk_cnt++; if (level !== 0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
        chk_cnt++; if (lives !== LV) $display("FAIL reset_lives: got %0d want %0d", lives, LV); else pass_cnt++;
        chk_cnt++; if (respawn !== 0) $display("FAIL reset_respawn: got %0d want 0", respawn); else pass_cnt++;
        chk_cnt++; if (snd_if.snd_valid !== 0) $display("FAIL reset_snd_valid: got %0d want 0", snd_if.snd_valid); else pass_cnt++;
        chk_cnt++; if (snd_if.snd_id !== UI_PRESS) $display("FAIL reset_snd_id: got %0d want 0", snd_if.snd_id); else pass_cnt++;
        chk_cnt++; if (snd_overflow !== 0) $display("FAIL reset_overflow: got %0d want 0", snd_overflow); else pass_cnt++;
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic test_basic_start();
        do_reset();
        start = 1;
        tick();
        chk_cnt++; if (state !== PLAYING) $display("FAIL start_state: got %0d want %0d", state, PLAYING); else pass_cnt++;
        chk_cnt++; if (level !== 0) $display("FAIL start_level: got %0d want 0", level); else pass_cnt++;
        chk_cnt++; if (lives !== LV) $display("FAIL start_lives: got %0d want %0d", lives, LV); else pass_cnt++;
        chk_cnt++; if (respawn !== 1) $display("FAIL start_respawn: got %0d want 1", respawn); else pass_cnt++;
        chk_cnt++; if (snd_if.snd_valid !== 1) $display("FAIL start_snd_valid: got %0d want 1", snd_if.snd_valid); else pass_cnt++;
        chk_cnt++; if (snd_if.snd_id !== UI_PRESS) $display("FAIL start_snd_id: got %0d want %0d", snd_if.snd_id, UI_PRESS); else pass_cnt++;
        start = 0;
        tick();
        chk_cnt++; if (respawn !== 0) $display("FAIL start_respawn_1cyc: got %0d want 0", respawn); else pass_cnt++;
    endtask

    task automatic test_win();
        sound_t exp_q[$];
        exp_q = '{UI_PRESS, NEXTLEVEL, NEXTLEVEL, NEXTLEVEL, CELEBRATION};
        do_reset();
        obs.delete();
        snd_if.snd_ready = 1;
        start = 1; tick_obs(); start = 0; tick_obs();
        for (int lv = 1; lv <= NL; lv++) begin
            reached_end = 1;
            tick_obs();
            if (lv < NL) begin
                chk_cnt++; if (level !== lv || respawn !== 1 || state !== PLAYING)
                    $display("FAIL win_level_step: got level %0d respawn %0d state %0d want level %0d respawn 1 state %0d", level, respawn, state, lv, PLAYING);
                else pass_cnt++;
            end else begin
                chk_cnt++; if (state !== WIN || level !== NL - 1)
                    $display("FAIL win_final: got state %0d level %0d want state %0d level %0d", state, level, WIN, NL - 1);
                else pass_cnt++;
            end
            reached_end = 0;
            tick_obs();
        end
        for (int i = 0; i < 4; i++) tick_obs();
        snd_if.snd_ready = 0;
        chk_cnt++; if (obs.size() != exp_q.size()) $display("FAIL win_snd_count: got %0d want %0d", obs.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk_cnt++; if (obs[i] !== exp_q[i]) $display("FAIL win_snd_order[%0d]: got %0d want %0d", i, obs[i], exp_q[i]); else pass_cnt++;
        end
    endtask

    task automatic test_death();
        int n;
        sound_t exp_q[$];
        exp_q = '{UI_PRESS, CRASH, GAMEOVER};
        do_reset();
        start = 1; tick(); start = 0; tick();
        collision = 1;
        tick();
        collision = 0;
        chk_cnt++; if (state !== DYING || lives !== LV - 1)
            $display("FAIL death_enter: got state %0d lives %0d want state %0d lives %0d", state, lives, DYING, LV - 1);
        else pass_cnt++;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state !== DYING) break;
            n++;
        end
        chk_cnt++; if (n != DC) $display("FAIL death_duration: got %0d cycles want %0d", n, DC); else pass_cnt++;
        chk_cnt++; if (state !== PLAYING || respawn !== 1)
            $display("FAIL death_respawn: got state %0d respawn %0d want state %0d respawn 1", state, respawn, PLAYING);
        else pass_cnt++;
        tick();
        collision = 1;
        tick();
        collision = 0;
        chk_cnt++; if (state !== GAME_OVER || lives !== 0 || level !== 0)
            $display("FAIL gameover: got state %0d lives %0d level %0d want state %0d lives 0 level 0", state, lives, level, GAME_OVER);
        else pass_cnt++;
        drain();
        chk_cnt++; if (obs.size() != exp_q.size()) $display("FAIL death_snd_count: got %0d want %0d", obs.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk_cnt++; if (obs[i] !== exp_q[i]) $display("FAIL death_snd_order[%0d]: got %0d want %0d", i, obs[i], exp_q[i]); else pass_cnt++;
        end
        start = 1; tick(); start = 0;
        chk_cnt++; if (state !== MENU || snd_if.snd_id !== UI_PRESS || snd_if.snd_valid !== 1)
            $display("FAIL gameover_to_menu: got state %0d snd_valid %0d snd_id %0d want state %0d valid 1 id %0d", state, snd_if.snd_valid, snd_if.snd_id, MENU, UI_PRESS);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_simultaneous_pause();
        sound_t exp_q[$];
        exp_q = '{UI_PRESS, CRASH};
        do_reset();
        start = 1; tick(); start = 0; tick();
        collision = 1; reached_end = 1;
        tick();
        collision = 0; reached_end = 0;
        chk_cnt++; if (state !== DYING || level !== 0 || lives !== LV - 1)
            $display("FAIL simul_priority: got state %0d level %0d lives %0d want state %0d level 0 lives %0d", state, level, lives, DYING, LV - 1);
        else pass_cnt++;
        for (int i = 0; i < 20 && state === DYING; i++) tick();
        drain();
        chk_cnt++; if (obs.size() != exp_q.size()) $display("FAIL simul_snd_count: got %0d want %0d", obs.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk_cnt++; if (obs[i] !== exp_q[i]) $display("FAIL simul_snd_order[%0d]: got %0d want %0d", i, obs[i], exp_q[i]); else pass_cnt++;
        end
        pause = 1; tick(); pause = 0;
        chk_cnt++; if (state !== PAUSED || snd_if.snd_id !== PAUSE)
            $display("FAIL pause_enter: got state %0d snd_id %0d want state %0d snd_id %0d", state, snd_if.snd_id, PAUSED, PAUSE);
        else pass_cnt++;
        collision = 1; tick(); tick();
        reached_end = 1; tick();
        collision = 0; reached_end = 0;
        tick();
        chk_cnt++; if (state !== PAUSED || lives !== LV - 1 || level !== 0)
            $display("FAIL paused_ignores: got state %0d lives %0d level %0d want state %0d lives %0d level 0", state, lives, level, PAUSED, LV - 1);
        else pass_cnt++;
        pause = 1; tick(); pause = 0;
        chk_cnt++; if (state !== PLAYING || respawn !== 0)
            $display("FAIL pause_exit: got state %0d respawn %0d want state %0d respawn 0", state, respawn, PLAYING);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_overflow();
        sound_t exp_q[$];
        exp_q = '{UI_PRESS, NEXTLEVEL, PAUSE, PAUSE};
        do_reset();
        start = 1; tick(); start = 0; tick();
        reached_end = 1; tick(); reached_end = 0; tick();
        pause = 1; tick(); pause = 0; tick();
        pause = 1; tick(); pause = 0; tick();
        chk_cnt++; if (snd_overflow !== 0 || snd_if.snd_id !== UI_PRESS)
            $display("FAIL ovf_before: got overflow %0d snd_id %0d want overflow 0 snd_id %0d", snd_overflow, snd_if.snd_id, UI_PRESS);
        else pass_cnt++;
        reached_end = 1; tick(); reached_end = 0;
        chk_cnt++; if (snd_overflow !== 1 || snd_if.snd_id !== UI_PRESS || snd_if.snd_valid !== 1 || level !== 2)
            $display("FAIL ovf_set: got overflow %0d snd_id %0d valid %0d level %0d want 1 %0d 1 2", snd_overflow, snd_if.snd_id, snd_if.snd_valid, level, UI_PRESS);
        else pass_cnt++;
        tick();
        drain();
        chk_cnt++; if (obs.size() != exp_q.size()) $display("FAIL ovf_snd_count: got %0d want %0d", obs.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk_cnt++; if (obs[i] !== exp_q[i]) $display("FAIL ovf_snd_order[%0d]: got %0d want %0d", i, obs[i], exp_q[i]); else pass_cnt++;
        end
        chk_cnt++; if (snd_overflow !== 1 || snd_if.snd_valid !== 0)
            $display("FAIL ovf_sticky: got overflow %0d valid %0d want overflow 1 valid 0", snd_overflow, snd_if.snd_valid);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1; tick(); start = 0; tick();
        collision = 1; tick(); collision = 0;
        tick();
        #2;
        reset = 1;
        #1;
        chk_cnt++; if (state !== MENU || level !== 0 || lives !== LV || respawn !== 0)
            $display("FAIL areset_ctrl: got state %0d level %0d lives %0d respawn %0d want %0d 0 %0d 0", state, level, lives, respawn, MENU, LV);
        else pass_cnt++;
        chk_cnt++; if (snd_if.snd_valid !== 0 || snd_if.snd_id !== UI_PRESS || snd_overflow !== 0)
            $display("FAIL areset_snd: got valid %0d id %0d overflow %0d want 0 0 0", snd_if.snd_valid, snd_if.snd_id, snd_overflow);
        else pass_cnt++;
        tick();
        reset = 0;
        for (int i = 0; i < 8; i++) tick();
        chk_cnt++; if (state !== MENU || snd_if.snd_valid !== 0)
            $display("FAIL areset_quiet: got state %0d valid %0d want %0d 0", state, snd_if.snd_valid, MENU);
        else pass_cnt++;
        start = 1; tick(); start = 0;
        chk_cnt++; if (snd_if.snd_valid !== 1 || snd_if.snd_id !== UI_PRESS)
            $display("FAIL areset_restart: got valid %0d id %0d want 1 %0d", snd_if.snd_valid, snd_if.snd_id, UI_PRESS);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            chk_cnt++;
            if ({state, level, lives, respawn, snd_if.snd_valid, snd_overflow} !==
                {m_state, LVL_W'(m_level), LIV_W'(m_lives), m_respawn, (m_q.size() > 0), m_ovf})
                $display("FAIL random_cycle %0d: got state %0d level %0d lives %0d respawn %0d valid %0d ovf %0d want %0d %0d %0d %0d %0d %0d",
                         i, state, level, lives, respawn, snd_if.snd_valid, snd_overflow,
                         m_state, m_level, m_lives, m_respawn, m_q.size() > 0, m_ovf);
            else pass_cnt++;
            if (m_q.size() > 0) begin
                chk_cnt++;
                if (snd_if.snd_id !== m_q[0]) $display("FAIL random_snd_id %0d: got %0d want %0d", i, snd_if.snd_id, m_q[0]);
                else pass_cnt++;
            end
            start            = ($urandom_range(0, 5) == 0);
            pause            = ($urandom_range(0, 9) == 0);
            collision        = ($urandom_range(0, 29) == 0);
            reached_end      = ($urandom_range(0, 3) == 0);
            snd_if.snd_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_start();
        test_win();
        test_death();
        test_simultaneous_pause();
        test_overflow();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
